// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: ALU op codes, arbiter FSM states and the ALU data width.
package alu_pkg;

  localparam int ALU_DATA_W = 16;

  typedef enum logic [2:0] {
    OP_SUB  = 3'd0,
    OP_ADD  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIV3 = 3'd3,
    OP_AND  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_RSV  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first set request at or after ptr_i wins,
// wrapping from NREQ-1 back to 0.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      int                cand;
      logic [IDX_W-1:0]  candIdx;
      cand = int'(ptr_i) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      candIdx = IDX_W'(cand);
      if (!any_o && req_i[candIdx]) begin
        any_o = 1'b1;
        idx_o = candIdx;
      end
    end
    if (any_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of the external 16-bit ALU among NREQ valid/ready requesters.
// Optional ALU_ARB_ILLEGAL_OP_EN: op 3'b111 is rejected with rsp_err instead of executed.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = ALU_DATA_W,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ*3-1:0]      req_op,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]      rsp_result,
  output logic                   rsp_zero,
  output logic                   rsp_neg,
  output logic                   rsp_err,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic [2:0]             alu_ctrl,
  input  logic [DATA_W-1:0]      alu_result,
  input  logic                   alu_zero,
  output logic                   busy
);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  rrPtr_q, rrPtr_d;
  logic [IDX_W-1:0]  gntIdx_q, gntIdx_d;
  logic [DATA_W-1:0] opA_q, opA_d;
  logic [DATA_W-1:0] opB_q, opB_d;
  logic [2:0]        opC_q, opC_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              neg_q, neg_d;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic              err_q, err_d;
`endif

  logic [NREQ-1:0]   arbGnt;
  logic [IDX_W-1:0]  arbIdx;
  logic              arbAny;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i (req_valid),
    .ptr_i (rrPtr_q),
    .gnt_o (arbGnt),
    .idx_o (arbIdx),
    .any_o (arbAny)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rrPtr_q  <= '0;
      gntIdx_q <= '0;
      opA_q    <= '0;
      opB_q    <= '0;
      opC_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rrPtr_q  <= rrPtr_d;
      gntIdx_q <= gntIdx_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      opC_q    <= opC_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
`ifdef ALU_ARB_ILLEGAL_OP_EN
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    rrPtr_d  = rrPtr_q;
    gntIdx_d = gntIdx_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    opC_d    = opC_q;
    result_d = result_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (arbAny) begin
          gntIdx_d = arbIdx;
          opA_d    = req_a[int'(arbIdx)*DATA_W +: DATA_W];
          opB_d    = req_b[int'(arbIdx)*DATA_W +: DATA_W];
          opC_d    = req_op[int'(arbIdx)*3 +: 3];
          state_d  = EXEC;
`ifdef ALU_ARB_ILLEGAL_OP_EN
          // Reserved op never reaches the ALU; answer straight from IDLE with a zeroed result.
          if (opC_d == OP_RSV) begin
            err_d    = 1'b1;
            opC_d    = 3'b000;
            result_d = '0;
            zero_d   = 1'b0;
            neg_d    = 1'b0;
            state_d  = RESP;
          end else begin
            err_d    = 1'b0;
          end
`endif
        end
      end
      EXEC: begin
        result_d = alu_result;
        zero_d   = alu_zero;
        neg_d    = alu_result[DATA_W-1];
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready[gntIdx_q]) begin
          state_d = IDLE;
          rrPtr_d = (gntIdx_q == IDX_W'(NREQ-1)) ? '0 : gntIdx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[gntIdx_q] = 1'b1;
  end

  assign req_ready  = (state_q == IDLE) ? arbGnt : '0;
  assign busy       = (state_q != IDLE);
  assign alu_a      = opA_q;
  assign alu_b      = opB_q;
  assign alu_ctrl   = opC_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_neg    = neg_q;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  assign rsp_err    = err_q;
`else
  assign rsp_err    = 1'b0;
`endif

endmodule
